// File: rtl/mem_stage.sv
// mem_stage: pipeline memory-access stage; aligns loads/stores over a req/ack
// data-memory port and registers a 43-bit result bus toward write-back.
module mem_stage #(
    parameter int ADDR_W   = 32,
    parameter int BUS_IN_W = 79
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                exe_valid,
    input  logic [BUS_IN_W-1:0] exe_mem_bus,
    output logic                mem_allowin,
    output logic                dm_req,
    output logic                dm_wr,
    output logic [3:0]          dm_wen,
    output logic [ADDR_W-1:0]   dm_addr,
    output logic [31:0]         dm_wdata,
    input  logic                dm_ack,
    input  logic [31:0]         dm_rdata,
    output logic [42:0]         MEM_WB_BUS,
    output logic                addr_exc,
    output logic [ADDR_W-1:0]   bad_vaddr
);
    typedef enum logic {IDLE, WAIT} state_t;

    state_t              state_q;
    logic [10:0]         meta_q;
    logic [3:0]          op_q;
    logic [31:0]         res_q;
    logic                dm_req_q, dm_wr_q, addr_exc_q;
    logic [3:0]          dm_wen_q;
    logic [ADDR_W-1:0]   dm_addr_q, bad_vaddr_q;
    logic [31:0]         dm_wdata_q;
    logic [42:0]         wb_q;

    logic [3:0]  op;
    logic [31:0] res, st;
    logic        is_ld, is_st, is_h, is_w, mis;
    logic [3:0]  wen_d;
    logic [31:0] wdata_d, w_data_d;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        op       = exe_mem_bus[67:64];
        res      = exe_mem_bus[63:32];
        st       = exe_mem_bus[31:0];
        is_ld    = op >= 4'd1 && op <= 4'd5;
        is_st    = op >= 4'd9 && op <= 4'd11;
        is_h     = op == 4'd3 || op == 4'd4 || op == 4'd10;
        is_w     = op == 4'd5 || op == 4'd11;
        mis      = (is_h & res[0]) | (is_w & |res[1:0]);
        wen_d    = op == 4'd9  ? 4'b0001 << res[1:0] :
                   op == 4'd10 ? (res[1] ? 4'b1100 : 4'b0011) :
                   op == 4'd11 ? 4'b1111 : 4'b0000;
        wdata_d  = op == 4'd9  ? {4{st[7:0]}} :
                   op == 4'd10 ? {2{st[15:0]}} :
                   op == 4'd11 ? st : 32'd0;
        byte_v   = res_q[1] ? (res_q[0] ? dm_rdata[31:24] : dm_rdata[23:16])
                            : (res_q[0] ? dm_rdata[15:8]  : dm_rdata[7:0]);
        half_v   = res_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        // op_q only ever holds a memory op here, so < 6 means load
        w_data_d = op_q == 4'd1 ? {{24{byte_v[7]}}, byte_v} :
                   op_q == 4'd2 ? {24'd0, byte_v} :
                   op_q == 4'd3 ? {{16{half_v[15]}}, half_v} :
                   op_q == 4'd4 ? {16'd0, half_v} :
                   op_q == 4'd5 ? dm_rdata : res_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            meta_q      <= '0;
            op_q        <= '0;
            res_q       <= '0;
            dm_req_q    <= 1'b0;
            dm_wr_q     <= 1'b0;
            dm_wen_q    <= '0;
            dm_addr_q   <= '0;
            dm_wdata_q  <= '0;
            addr_exc_q  <= 1'b0;
            bad_vaddr_q <= '0;
            wb_q        <= '0;
        end else begin
            addr_exc_q <= 1'b0;
            wb_q       <= '0;
            if (state_q == IDLE) begin
                if (exe_valid) begin
                    meta_q <= exe_mem_bus[78:68];
                    op_q   <= op;
                    res_q  <= res;
                    if (!(is_ld | is_st)) begin
                        wb_q <= {exe_mem_bus[78:68], res};
                    end else if (mis) begin
                        addr_exc_q  <= 1'b1;
                        bad_vaddr_q <= res;
                    end else begin
                        dm_req_q   <= 1'b1;
                        dm_wr_q    <= is_st;
                        dm_wen_q   <= wen_d;
                        dm_addr_q  <= {res[31:2], 2'b00};
                        dm_wdata_q <= wdata_d;
                        state_q    <= WAIT;
                    end
                end
            end else if (dm_req_q && dm_ack) begin
                dm_req_q <= 1'b0;
                wb_q     <= {meta_q, w_data_d};
            end else if (!dm_req_q) begin
                // result cycle: allowin stays low one cycle after the ack
                state_q <= IDLE;
            end
        end
    end

    assign mem_allowin = state_q == IDLE;
    assign dm_req      = dm_req_q;
    assign dm_wr       = dm_wr_q;
    assign dm_wen      = dm_wen_q;
    assign dm_addr     = dm_addr_q;
    assign dm_wdata    = dm_wdata_q;
    assign MEM_WB_BUS  = wb_q;
    assign addr_exc    = addr_exc_q;
    assign bad_vaddr   = bad_vaddr_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed checks of mem_stage with hand-computed expectations.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        resetn, exe_valid, mem_allowin, dm_req, dm_wr, dm_ack, addr_exc;
    logic [78:0] exe_mem_bus;
    logic [3:0]  dm_wen;
    logic [31:0] dm_addr, dm_wdata, dm_rdata, bad_vaddr;
    logic [42:0] MEM_WB_BUS;
    int checks = 0, failures = 0;

    mem_stage dut (
        .clk(clk), .resetn(resetn), .exe_valid(exe_valid), .exe_mem_bus(exe_mem_bus),
        .mem_allowin(mem_allowin), .dm_req(dm_req), .dm_wr(dm_wr), .dm_wen(dm_wen),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .MEM_WB_BUS(MEM_WB_BUS), .addr_exc(addr_exc), .bad_vaddr(bad_vaddr)
    );

    always #5 clk = ~clk;

    function automatic logic [78:0] mk(input logic en, input logic [1:0] aim, input logic [4:0] rd,
                                       input logic [2:0] sel, input logic [3:0] op,
                                       input logic [31:0] res, input logic [31:0] st);
        return {en, aim, rd, sel, op, res, st};
    endfunction

    function automatic logic [42:0] wbv(input logic en, input logic [1:0] aim, input logic [4:0] rd,
                                        input logic [2:0] sel, input logic [31:0] w);
        return {en, aim, rd, sel, w};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 1'b0; exe_valid = 1'b0; exe_mem_bus = '0; dm_ack = 1'b0; dm_rdata = '0;
        #12;
        chk("rst_wb", MEM_WB_BUS, 0);
        chk("rst_req", dm_req, 0);
        chk("rst_wr", dm_wr, 0);
        chk("rst_wen", dm_wen, 0);
        chk("rst_addr", dm_addr, 0);
        chk("rst_wdata", dm_wdata, 0);
        chk("rst_exc", addr_exc, 0);
        chk("rst_bad", bad_vaddr, 0);
        chk("rst_allow", mem_allowin, 1);
        resetn = 1'b1;

        exe_mem_bus = mk(1, 2'b01, 5'd3, 3'd0, 4'd0, 32'hDEADBEEF, 32'h0);
        exe_valid = 1'b1;
        step;
        chk("none_wb", MEM_WB_BUS, wbv(1, 2'b01, 5'd3, 3'd0, 32'hDEADBEEF));
        chk("none_allow", mem_allowin, 1);
        exe_valid = 1'b0;
        step;
        chk("idle_wb", MEM_WB_BUS, 0);

        exe_mem_bus = mk(1, 2'b10, 5'd7, 3'd1, 4'd1, 32'h1003, 32'h0);
        exe_valid = 1'b1;
        step;
        chk("lb_req1", dm_req, 1);
        chk("lb_addr", dm_addr, 32'h1000);
        chk("lb_wen", dm_wen, 0);
        chk("lb_wr", dm_wr, 0);
        chk("lb_allow1", mem_allowin, 0);
        chk("lb_wb1", MEM_WB_BUS[42], 0);
        exe_mem_bus = mk(1, 2'b11, 5'd31, 3'd7, 4'd0, 32'h55555555, 32'h0);
        step;
        chk("lb_req2", dm_req, 1);
        chk("lb_addr2", dm_addr, 32'h1000);
        chk("lb_wb2", MEM_WB_BUS[42], 0);
        exe_valid = 1'b0;
        step;
        chk("lb_req3", dm_req, 1);
        dm_ack = 1'b1; dm_rdata = 32'h80FF0000;
        step;
        dm_ack = 1'b0;
        chk("lb_req_drop", dm_req, 0);
        chk("lb_wb", MEM_WB_BUS, wbv(1, 2'b10, 5'd7, 3'd1, 32'hFFFFFF80));
        chk("lb_allow_d", mem_allowin, 0);
        step;
        chk("lb_allow_i", mem_allowin, 1);
        chk("lb_wb_i", MEM_WB_BUS, 0);

        exe_mem_bus = mk(1, 2'b10, 5'd7, 3'd1, 4'd2, 32'h1003, 32'h0);
        exe_valid = 1'b1;
        step;
        exe_valid = 1'b0;
        chk("lbu_req", dm_req, 1);
        dm_ack = 1'b1;
        step;
        chk("lbu_wb", MEM_WB_BUS, wbv(1, 2'b10, 5'd7, 3'd1, 32'h00000080));
        step;
        dm_ack = 1'b0;
        chk("ack_noreq_wb", MEM_WB_BUS, 0);
        chk("ack_noreq_req", dm_req, 0);

        exe_mem_bus = mk(0, 2'b00, 5'd0, 3'd0, 4'd10, 32'h2002, 32'h1234ABCD);
        exe_valid = 1'b1;
        chk("sh_allow0", mem_allowin, 1);
        step;
        exe_valid = 1'b0;
        chk("sh_req", dm_req, 1);
        chk("sh_wr", dm_wr, 1);
        chk("sh_wen", dm_wen, 4'b1100);
        chk("sh_wdata", dm_wdata, 32'hABCDABCD);
        chk("sh_addr", dm_addr, 32'h2000);
        chk("sh_allow1", mem_allowin, 0);
        dm_ack = 1'b1;
        step;
        dm_ack = 1'b0;
        chk("sh_req_drop", dm_req, 0);
        chk("sh_allow2", mem_allowin, 0);
        chk("sh_wb", MEM_WB_BUS, wbv(0, 2'b00, 5'd0, 3'd0, 32'h2002));
        step;
        chk("sh_allow3", mem_allowin, 1);

        exe_mem_bus = mk(0, 2'b00, 5'd0, 3'd0, 4'd9, 32'h7001, 32'h000000A5);
        exe_valid = 1'b1;
        step;
        exe_valid = 1'b0;
        chk("sb_wen", dm_wen, 4'b0010);
        chk("sb_wdata", dm_wdata, 32'hA5A5A5A5);
        dm_ack = 1'b1;
        step;
        dm_ack = 1'b0;
        step;

        exe_mem_bus = mk(1, 2'b01, 5'd4, 3'd2, 4'd3, 32'h8002, 32'h0);
        exe_valid = 1'b1;
        step;
        exe_valid = 1'b0;
        chk("lh_wen", dm_wen, 0);
        dm_ack = 1'b1; dm_rdata = 32'h80011234;
        step;
        dm_ack = 1'b0;
        chk("lh_wb", MEM_WB_BUS, wbv(1, 2'b01, 5'd4, 3'd2, 32'hFFFF8001));
        step;

        exe_mem_bus = mk(1, 2'b00, 5'd2, 3'd0, 4'd5, 32'h3001, 32'h0);
        exe_valid = 1'b1;
        step;
        chk("mis_req", dm_req, 0);
        chk("mis_exc", addr_exc, 1);
        chk("mis_bad", bad_vaddr, 32'h3001);
        chk("mis_wb", MEM_WB_BUS, 0);
        chk("mis_allow", mem_allowin, 1);
        exe_mem_bus = mk(1, 2'b11, 5'd9, 3'd2, 4'd0, 32'h0BADF00D, 32'h0);
        step;
        chk("mis_next_wb", MEM_WB_BUS, wbv(1, 2'b11, 5'd9, 3'd2, 32'h0BADF00D));
        chk("mis_exc_drop", addr_exc, 0);
        chk("mis_bad_hold", bad_vaddr, 32'h3001);
        exe_mem_bus = mk(0, 2'b00, 5'd0, 3'd0, 4'd10, 32'h5001, 32'h0);
        step;
        chk("mis2_exc", addr_exc, 1);
        chk("mis2_bad", bad_vaddr, 32'h5001);
        exe_mem_bus = mk(1, 2'b00, 5'd1, 3'd0, 4'd4, 32'h6003, 32'h0);
        step;
        chk("mis3_exc", addr_exc, 1);
        chk("mis3_bad", bad_vaddr, 32'h6003);
        exe_valid = 1'b0;
        step;
        chk("mis3_exc_drop", addr_exc, 0);
        chk("mis3_bad_hold", bad_vaddr, 32'h6003);

        exe_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exe_mem_bus = mk(1, 2'b10, 5'(i + 10), 3'd5, 4'd0, 32'h11111111 * (i + 1), 32'h0);
            chk("b2b_allow", mem_allowin, 1);
            step;
            chk("b2b_wb", MEM_WB_BUS, wbv(1, 2'b10, 5'(i + 10), 3'd5, 32'h11111111 * (i + 1)));
        end
        exe_valid = 1'b0;
        step;

        exe_mem_bus = mk(1, 2'b01, 5'd6, 3'd0, 4'd5, 32'h4000, 32'h0);
        exe_valid = 1'b1;
        step;
        exe_valid = 1'b0;
        chk("rstw_req", dm_req, 1);
        #2 resetn = 1'b0;
        #1;
        chk("rstw_req0", dm_req, 0);
        chk("rstw_wb", MEM_WB_BUS, 0);
        chk("rstw_allow", mem_allowin, 1);
        chk("rstw_addr", dm_addr, 0);
        step;
        resetn = 1'b1;
        step;
        chk("post_req", dm_req, 0);
        chk("post_allow", mem_allowin, 1);
        chk("post_wb", MEM_WB_BUS, 0);
        step;
        chk("post_wb2", MEM_WB_BUS, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline memory-access stage. Sits directly upstream of the write-back stage and produces its 43-bit `MEM_WB_BUS`.
- Accepts one instruction per handshake from execute.
- Performs loads and stores through a req/ack data-memory port, with byte/halfword alignment and sign/zero extension.
- Registers the result toward write-back. Write-back never stalls; every valid output is consumed on the cycle it is presented.

Parameters:
- `ADDR_W`, 32, data-memory address width (must be 32; low 2 bits used for alignment).
- `BUS_IN_W`, 79, width of `exe_mem_bus`.

Ports:
- `clk`  input  1  sole clock, rising edge.
- `resetn`  input  1  asynchronous, active-low reset.
- `exe_valid`  input  1  `exe_mem_bus` holds a valid instruction.
- `exe_mem_bus`  input  79  `{en[78], aim[77:76], rd[75:71], sel[70:68], mem_op[67:64], result[63:32], st_data[31:0]}`.
- `mem_allowin`  output  1  stage can accept this cycle.
- `dm_req`  output  1  data-memory request.
- `dm_wr`  output  1  1 = store, 0 = load.
- `dm_wen`  output  4  byte enables, stores only; 0 for loads.
- `dm_addr`  output  32  word-aligned address (`result[31:2]`, 2'b00).
- `dm_wdata`  output  32  store data replicated into the addressed lanes.
- `dm_ack`  input  1  completes the request in the cycle `dm_req & dm_ack`.
- `dm_rdata`  input  32  read word; valid in the ack cycle.
- `MEM_WB_BUS`  output  43  `{en, aim[1:0], rd[4:0], sel[2:0], w_data[31:0]}`.
- `addr_exc`  output  1  one-cycle pulse: misaligned access (AdEL/AdES).
- `bad_vaddr`  output  32  offending address; held until the next `addr_exc`.

Behaviour:
- **mem_op encoding:**
  - 0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 9 SB, 10 SH, 11 SW.
  - All other values are treated as NONE.
- **Reset values:**
  - `MEM_WB_BUS` = 0 (en = 0).
  - `dm_req` = 0, `dm_wr` = 0, `dm_wen` = 0, `dm_addr` = 0, `dm_wdata` = 0.
  - `addr_exc` = 0, `bad_vaddr` = 0.
  - state = IDLE, so `mem_allowin` = 1.
  - Reset takes effect immediately and asynchronously, including mid-request. `dm_req` drops at once and the pending instruction is discarded.
- **States:** IDLE, WAIT. `mem_allowin` = (state == IDLE).
- **IDLE, accept on `exe_valid`:** the stage latches the bus fields. Then, by case:
  - **NONE:** next cycle `MEM_WB_BUS` = `{en, aim, rd, sel, result}`; stay IDLE. Latency 1.
  - **Misaligned** (halfword with `addr[0]` = 1, or word with `addr[1:0]` ≠ 0):
    - No memory request is made.
    - Next cycle: `MEM_WB_BUS` en = 0, `addr_exc` = 1, `bad_vaddr` = `result`.
    - Stay IDLE.
  - **Aligned load/store:** next cycle `dm_req` = 1 with `dm_wr`, `dm_wen`, `dm_addr`, `dm_wdata` valid; go to WAIT.
- **IDLE, no `exe_valid`:** `MEM_WB_BUS` en = 0 next cycle.
- **WAIT:**
  - `dm_req` and all `dm_*` outputs are held stable until the ack cycle.
  - `MEM_WB_BUS` en = 0 while waiting.
  - On `dm_ack`: `dm_req` drops next cycle and the result is registered for next cycle; go to IDLE.
  - Load: `w_data` is the extracted value.
  - Store: the output carries the latched en/aim/rd/sel with `w_data` = `result`. Execute sets en = 0 for stores; the stage passes en through unchanged.
  - Minimum load/store latency is 2 cycles (ack in the first req cycle).
- **Store lanes:**
  - SB: `wen` = 1 << `addr[1:0]`, `wdata` = `{4{st_data[7:0]}}`.
  - SH: `wen` = `addr[1]` ? 4'b1100 : 4'b0011, `wdata` = `{2{st_data[15:0]}}`.
  - SW: `wen` = 4'b1111, `wdata` = `st_data`.
- **Load extract:**
  - LB/LBU: byte `addr[1:0]` of `dm_rdata`, sign-extended (LB) or zero-extended (LBU).
  - LH/LHU: halfword `addr[1]`, sign-extended (LH) or zero-extended (LHU).
  - LW: the full word.
- **Boundary conditions:**
  - `dm_ack` is ignored when `dm_req` = 0.
  - `exe_valid` is ignored in WAIT; execute must hold its bus until `mem_allowin`.
  - In the cycle WAIT returns to IDLE, `mem_allowin` is still 0 (registered state). A new instruction is accepted one cycle after ack.
  - `addr_exc` is a single-cycle pulse, even for back-to-back misaligned instructions (pulses on consecutive cycles).

Test Plan:
1. Reset mid-WAIT: LW issued, `dm_ack` withheld, `resetn` pulled low → `dm_req` = 0 immediately, `MEM_WB_BUS` = 0; after release `mem_allowin` = 1 and no stale output appears.
2. NONE op, `{en=1, aim=01, rd=3, sel=0, result=32'hDEADBEEF}` → next cycle `MEM_WB_BUS` = `{1, 01, 3, 0, DEADBEEF}` (lo_en path).
3. LB at addr 0x1003, `dm_rdata` = 0x80FF_0000, ack after 3 wait cycles → `dm_req` held 3 cycles with `dm_addr` = 0x1000, `dm_wen` = 0; one cycle after ack `w_data` = 0xFFFF_FF80. Repeat as LBU → 0x0000_0080.
4. SH at 0x2002, `st_data` = 0x1234_ABCD, immediate ack → `dm_wen` = 1100, `dm_wdata` = 0xABCD_ABCD, `dm_wr` = 1; `mem_allowin` low for exactly 2 cycles.
5. LW at 0x3001 → no `dm_req`, `addr_exc` pulses 1 cycle, `bad_vaddr` = 0x3001, `MEM_WB_BUS` en = 0; the following NONE op completes normally.
6. Back-to-back NONE ops with `exe_valid` held high for 4 cycles → 4 consecutive valid `MEM_WB_BUS` outputs, `mem_allowin` constantly 1.
